// File: rtl/mips_core_pkg.sv
// Shared core types: program-counter word and the hazard sequencer's drain FSM states.
package mips_core_pkg;

    typedef logic [31:0] pc_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRAIN   = 2'd1,
        RESTART = 2'd2
    } seq_state_t;

endpackage

// File: rtl/redirect_arbiter.sv
// Picks the oldest (highest-index) eligible redirect request among the pipeline stages.
module redirect_arbiter #(
    parameter int  NUM_STAGES = 5,
    localparam int IDX_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic [NUM_STAGES-1:0] req,
    output logic                  win_valid,
    output logic [IDX_W-1:0]      win_idx
);

    // NOTE: every output gets a default before the loop so no latch can be inferred.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (req[i]) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard control: stall/flush generation, redirect arbitration, full-drain FSM,
// deadlock watchdog and saturating performance counters.
module hazard_sequencer
    import mips_core_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int CNT_W      = 32,
    parameter int WDOG_LIMIT = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_STAGES-1:0] hold_req,
    input  logic [NUM_STAGES-1:0] redirect_valid,
    input  pc_t  [NUM_STAGES-1:0] redirect_pc,
    input  logic [NUM_STAGES-1:0] stage_valid,
    input  logic                  flush_all_req,
    input  pc_t                   flush_all_pc,
    output logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] flush,
    output logic                  load_pc_we,
    output pc_t                   load_pc_new_pc,
    output logic                  busy,
    output logic                  deadlock,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      redirect_cnt,
    output logic [CNT_W-1:0]      drain_cnt
);

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int WD_W  = $clog2(WDOG_LIMIT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_LIMIT);

    seq_state_t            state, state_next;
    pc_t                   drain_pc;
    logic [WD_W-1:0]       wdog_cnt, wdog_next;
    logic [NUM_STAGES-1:0] stall_base, flush_base, redirect_req;
    logic                  redir_win;
    logic [IDX_W-1:0]      redir_idx;
    logic                  upper_empty;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    // Held stage stalls itself and everything younger; bubble goes in right behind it.
    always_comb begin
        stall_base                 = '0;
        flush_base                 = '0;
        stall_base[NUM_STAGES-1]   = hold_req[NUM_STAGES-1];
        flush_base[NUM_STAGES-1]   = hold_req[NUM_STAGES-1];
        for (int i = NUM_STAGES - 2; i >= 0; i--) begin
            stall_base[i] = hold_req[i] | stall_base[i+1];
            flush_base[i] = hold_req[i] & ~stall_base[i+1];
        end
    end

    assign redirect_req = (state == IDLE) ? (redirect_valid & ~stall_base) : '0;

    redirect_arbiter #(
        .NUM_STAGES(NUM_STAGES)
    ) u_redirect_arbiter (
        .req      (redirect_req),
        .win_valid(redir_win),
        .win_idx  (redir_idx)
    );

    always_comb begin
        stall          = stall_base;
        flush          = flush_base;
        load_pc_we     = 1'b0;
        load_pc_new_pc = drain_pc;
        if (redir_win) begin
            stall[0]       = 1'b0;
            load_pc_we     = 1'b1;
            load_pc_new_pc = redirect_pc[redir_idx];
            for (int i = 0; i < NUM_STAGES; i++) begin
                if (i < int'(redir_idx)) flush[i] = 1'b1;
            end
        end
        if (state == DRAIN) begin
            stall[0] = 1'b1;
            flush[0] = 1'b1;
        end
        if (state == RESTART) load_pc_we = 1'b1;
        // A PC write must never escape while reset is held, even mid-restart.
        if (!rst_n) load_pc_we = 1'b0;
    end

    assign upper_empty = ((stage_valid >> 1) == '0);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (flush_all_req) state_next = DRAIN;
            DRAIN:   if (upper_empty)   state_next = RESTART;
            RESTART: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        if (!stall[0])             wdog_next = '0;
        else if (wdog_cnt == WD_MAX) wdog_next = wdog_cnt;
        else                       wdog_next = wdog_cnt + WD_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            drain_pc     <= '0;
            busy         <= 1'b0;
            wdog_cnt     <= '0;
            deadlock     <= 1'b0;
            stall_cnt    <= '0;
            redirect_cnt <= '0;
            drain_cnt    <= '0;
        end else begin
            state        <= state_next;
            busy         <= (state_next != IDLE);
            if ((state == IDLE) && flush_all_req) drain_pc <= flush_all_pc;
            wdog_cnt     <= wdog_next;
            deadlock     <= deadlock | (wdog_next == WD_MAX);
            stall_cnt    <= sat_inc(stall_cnt, stall[0]);
            redirect_cnt <= sat_inc(redirect_cnt, redir_win);
            drain_cnt    <= sat_inc(drain_cnt, state == RESTART);
        end
    end

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_hazard_sequencer;

    localparam int NS = 5;
    localparam int CW = 8;
    localparam int WL = 1024;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NS-1:0]      hold_req, redirect_valid, stage_valid;
    logic [NS-1:0][31:0] redirect_pc;
    logic               flush_all_req;
    logic [31:0]        flush_all_pc;
    logic [NS-1:0]      stall, flush;
    logic               load_pc_we, busy, deadlock;
    logic [31:0]        load_pc_new_pc;
    logic [CW-1:0]      stall_cnt, redirect_cnt, drain_cnt;

    hazard_sequencer #(.NUM_STAGES(NS), .CNT_W(CW), .WDOG_LIMIT(WL)) dut (
        .clk(clk), .rst_n(rst_n), .hold_req(hold_req), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .stage_valid(stage_valid), .flush_all_req(flush_all_req),
        .flush_all_pc(flush_all_pc), .stall(stall), .flush(flush), .load_pc_we(load_pc_we),
        .load_pc_new_pc(load_pc_new_pc), .busy(busy), .deadlock(deadlock),
        .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt), .drain_cnt(drain_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: what the sequencer is doing, in plain terms.
    bit draining, restarting, m_dead;
    logic [31:0] m_pc;
    int m_stall_cnt, m_redir_cnt, m_drain_cnt, m_wdog;
    // Model outputs for the current cycle.
    logic [NS-1:0] e_stall, e_flush;
    logic e_we;
    logic [31:0] e_pc;
    int e_win;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit any_hold_from(input int i);
        for (int k = i; k < NS; k++) if (hold_req[k]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_comb();
        for (int i = 0; i < NS; i++) begin
            e_stall[i] = any_hold_from(i);
            e_flush[i] = hold_req[i] && !any_hold_from(i + 1);
        end
        e_win = -1;
        if (!draining && !restarting)
            for (int j = 0; j < NS; j++) if (redirect_valid[j] && !e_stall[j]) e_win = j;
        e_we = 1'b0;
        e_pc = 32'h0;
        if (e_win >= 0) begin
            e_stall[0] = 1'b0;
            for (int k = 0; k < e_win; k++) e_flush[k] = 1'b1;
            e_we = 1'b1;
            e_pc = redirect_pc[e_win];
        end
        if (draining) begin
            e_stall[0] = 1'b1;
            e_flush[0] = 1'b1;
        end
        if (restarting) begin
            e_we = 1'b1;
            e_pc = m_pc;
        end
        if (!rst_n) e_we = 1'b0;
    endtask

    task automatic model_clear();
        draining = 0; restarting = 0; m_dead = 0; m_pc = 0;
        m_stall_cnt = 0; m_redir_cnt = 0; m_drain_cnt = 0; m_wdog = 0;
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_clear();
            return;
        end
        if (e_stall[0] && m_stall_cnt < CNT_MAX) m_stall_cnt++;
        if (e_win >= 0 && m_redir_cnt < CNT_MAX) m_redir_cnt++;
        if (restarting && m_drain_cnt < CNT_MAX) m_drain_cnt++;
        m_wdog = e_stall[0] ? ((m_wdog + 1 > WL) ? WL : m_wdog + 1) : 0;
        if (m_wdog == WL) m_dead = 1;
        if (restarting) restarting = 0;
        else if (draining) begin
            if (stage_valid[NS-1:1] == 0) begin
                draining = 0;
                restarting = 1;
            end
        end else if (flush_all_req) begin
            draining = 1;
            m_pc = flush_all_pc;
        end
    endtask

    // Apply the current inputs for one cycle: check mid-cycle, then advance the model.
    task automatic apply();
        #2;
        model_comb();
        check("stall", stall, e_stall);
        check("flush", flush, e_flush);
        check("load_pc_we", load_pc_we, e_we);
        if (e_we) check("load_pc_new_pc", load_pc_new_pc, e_pc);
        check("busy", busy, draining || restarting);
        check("deadlock", deadlock, m_dead);
        check("stall_cnt", stall_cnt, m_stall_cnt);
        check("redirect_cnt", redirect_cnt, m_redir_cnt);
        check("drain_cnt", drain_cnt, m_drain_cnt);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        hold_req = '0; redirect_valid = '0; stage_valid = '0;
        redirect_pc = '0; flush_all_req = 1'b0; flush_all_pc = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        apply();
        rst_n = 1'b1;
    endtask

    int busy_cycles, we_cycles;
    logic [31:0] we_pc;

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        rst_n = 1'b1;

        // Reset state
        #2;
        check("reset_busy", busy, 1'b0);
        check("reset_stall_cnt", stall_cnt, '0);
        #(-2 + 2);

        // Test 1: MEM hold
        do_reset();
        hold_req = 5'b01000;
        for (int c = 0; c < 3; c++) begin
            #2;
            check("t1_stall", stall, 5'b01111);
            check("t1_flush", flush, 5'b01000);
            check("t1_stall_cnt", stall_cnt, CW'(c));
            #(-2 + 2);
            apply();
        end

        // Test 2: two redirects, oldest wins
        do_reset();
        redirect_valid = 5'b00110;
        redirect_pc[2] = 32'h100;
        redirect_pc[1] = 32'h200;
        #2;
        check("t2_we", load_pc_we, 1'b1);
        check("t2_pc", load_pc_new_pc, 32'h100);
        check("t2_flush", flush, 5'b00011);
        apply();
        idle_inputs();
        #2;
        check("t2_redirect_cnt", redirect_cnt, 8'd1);
        apply();

        // Test 3: redirect blocked by a downstream hold
        do_reset();
        redirect_valid = 5'b00100;
        redirect_pc[2] = 32'hABC0;
        hold_req = 5'b01000;
        for (int c = 0; c < 3; c++) begin
            #2;
            check("t3_blocked_we", load_pc_we, 1'b0);
            apply();
        end
        hold_req = '0;
        #2;
        check("t3_we", load_pc_we, 1'b1);
        check("t3_pc", load_pc_new_pc, 32'hABC0);
        apply();
        redirect_valid = '0;
        apply();

        // Test 4: full drain; a second request mid-drain must be ignored
        do_reset();
        busy_cycles = 0; we_cycles = 0; we_pc = '0;
        for (int c = 0; c < 8; c++) begin
            flush_all_req = (c == 0) || (c == 2);
            flush_all_pc  = (c == 0) ? 32'h80 : 32'h999;
            stage_valid   = (c < 3) ? 5'b11110 : 5'b00001;
            #2;
            if (busy) busy_cycles++;
            if (load_pc_we) begin
                we_cycles++;
                we_pc = load_pc_new_pc;
            end
            apply();
        end
        idle_inputs();
        check("t4_busy_cycles", busy_cycles, 4);
        check("t4_we_cycles", we_cycles, 1);
        check("t4_we_pc", we_pc, 32'h80);
        #2;
        check("t4_drain_cnt", drain_cnt, 8'd1);
        apply();

        // Test 5: watchdog plus stall counter saturation
        do_reset();
        hold_req = 5'b00001;
        for (int c = 0; c < WL; c++) begin
            if (c == WL - 1) begin
                #2;
                check("t5_not_yet", deadlock, 1'b0);
                apply();
            end else apply();
        end
        hold_req = '0;
        for (int c = 0; c < 3; c++) apply();
        #2;
        check("t5_deadlock_sticky", deadlock, 1'b1);
        check("t5_stall_cnt_sat", stall_cnt, 8'hFF);
        apply();
        do_reset();
        #2;
        check("t5_deadlock_cleared", deadlock, 1'b0);
        apply();

        // Test 6: reset during DRAIN
        do_reset();
        flush_all_req = 1'b1;
        flush_all_pc  = 32'h4444;
        stage_valid   = 5'b00110;
        apply();
        flush_all_req = 1'b0;
        apply();
        apply();
        rst_n = 1'b0;
        #2;
        check("t6_we_in_reset", load_pc_we, 1'b0);
        apply();
        rst_n = 1'b1;
        idle_inputs();
        #2;
        check("t6_busy", busy, 1'b0);
        check("t6_stall_cnt", stall_cnt, '0);
        check("t6_drain_cnt", drain_cnt, '0);
        check("t6_we", load_pc_we, 1'b0);
        apply();
        apply();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(199) != 0);
            for (int i = 0; i < NS; i++) begin
                hold_req[i]       = ($urandom_range(7) == 0);
                redirect_valid[i] = ($urandom_range(3) == 0);
                redirect_pc[i]    = $urandom;
            end
            stage_valid   = ($urandom_range(2) == 0) ? 5'b00000 : 5'($urandom);
            flush_all_req = ($urandom_range(29) == 0);
            flush_all_pc  = $urandom;
            apply();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
